// File: rtl/wishbone_nn_stream_if_if.sv
// rtl/wishbone_nn_stream_if_if.sv - Wishbone slave bus bundle for the NN stream bridge
interface wishbone_nn_stream_if_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wishbone_nn_stream_if.sv
// rtl/wishbone_nn_stream_if.sv - Wishbone to NN-core bridge with TX/RX FIFOs and STATUS/CTRL registers
// Optional interrupt output is enabled by defining WB_NN_IRQ_EN.
module wishbone_nn_stream_if #(
  parameter logic [31:0] BASE_ADDRESS = 32'h30000000,
  parameter int          DATA_W       = 32,
  parameter int          TX_DEPTH     = 8,
  parameter int          RX_DEPTH     = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  wishbone_nn_stream_if_if.slave wbs,
  output logic              tx_valid_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_ready_i,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  output logic              rx_ready_o
`ifdef WB_NN_IRQ_EN
  ,
  output logic              irq_o
`endif
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [TX_AW-1:0]  tx_wr, tx_rd;
  logic [RX_AW-1:0]  rx_wr, rx_rd;
  logic [TX_AW:0]    tx_count;
  logic [RX_AW:0]    rx_count;
  logic              ack_q, overflow, underflow;
  logic [31:0]       dat_q, rd_word, ctrl_rd;

  logic hit_data, hit_status, hit_ctrl, accept;
  logic wr_data, rd_data, ctrl_wr, tx_flush, rx_flush, sticky_clr;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0] tx_cnt8, rx_cnt8;
  logic unused_ok;

  assign hit_data   = wbs.wbs_adr_i == BASE_ADDRESS;
  assign hit_status = wbs.wbs_adr_i == BASE_ADDRESS + 32'd4;
  assign hit_ctrl   = wbs.wbs_adr_i == BASE_ADDRESS + 32'd8;
  assign accept     = wbs.wbs_stb_i & wbs.wbs_cyc_i & (hit_data | hit_status | hit_ctrl) & ~ack_q;

  assign wr_data    = accept & wbs.wbs_we_i & hit_data;
  assign rd_data    = accept & ~wbs.wbs_we_i & hit_data;
  assign ctrl_wr    = accept & wbs.wbs_we_i & hit_ctrl & wbs.wbs_sel_i[0];
  assign tx_flush   = ctrl_wr & wbs.wbs_dat_i[0];
  assign rx_flush   = ctrl_wr & wbs.wbs_dat_i[1];
  assign sticky_clr = ctrl_wr & wbs.wbs_dat_i[2];

  assign tx_full  = tx_count == (TX_AW+1)'(TX_DEPTH);
  assign tx_empty = tx_count == '0;
  assign rx_full  = rx_count == (RX_AW+1)'(RX_DEPTH);
  assign rx_empty = rx_count == '0;

  assign tx_valid_o = ~tx_empty;
  assign tx_data_o  = tx_mem[tx_rd];
  assign rx_ready_o = wb_rst_ni & ~rx_full;

  // A head pop on the same edge frees the slot, so a write to a full TX is not dropped then.
  assign tx_pop  = tx_valid_o & tx_ready_i;
  assign tx_push = wr_data & (~tx_full | tx_pop);
  assign rx_push = rx_valid_i & rx_ready_o;
  assign rx_pop  = rd_data & ~rx_empty;

  assign tx_cnt8 = 8'(tx_count);
  assign rx_cnt8 = 8'(rx_count);

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign unused_ok = &{1'b0, wbs.wbs_sel_i[3:1], wbs.wbs_dat_i};

  always_comb begin
    rd_word = '0;
    if (!wbs.wbs_we_i) begin
      if (hit_data && !rx_empty)
        rd_word = 32'(rx_mem[rx_rd]);
      else if (hit_status)
        rd_word = {12'd0, underflow, overflow, rx_empty, tx_full, rx_cnt8, tx_cnt8};
      else if (hit_ctrl)
        rd_word = ctrl_rd;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= accept;
      if (accept) dat_q <= rd_word;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tx_wr <= '0; tx_rd <= '0; tx_count <= '0;
    end else if (tx_flush) begin
      tx_wr <= '0; tx_rd <= '0; tx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TX_AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + TX_AW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + (TX_AW+1)'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - (TX_AW+1)'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rx_wr <= '0; rx_rd <= '0; rx_count <= '0;
    end else if (rx_flush) begin
      rx_wr <= '0; rx_rd <= '0; rx_count <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + RX_AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + RX_AW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + (RX_AW+1)'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - (RX_AW+1)'(1);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge wb_clk_i) begin
    if (tx_push && !tx_flush) tx_mem[tx_wr] <= wbs.wbs_dat_i[DATA_W-1:0];
    if (rx_push && !rx_flush) rx_mem[rx_wr] <= rx_data_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (sticky_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_data && tx_full && !tx_pop) overflow <= 1'b1;
      if (rd_data && rx_empty)           underflow <= 1'b1;
    end
  end

`ifdef WB_NN_IRQ_EN
  logic irq_en;

  assign ctrl_rd = {28'd0, irq_en, 3'd0};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= wbs.wbs_dat_i[3];
      irq_o <= irq_en & (~rx_empty | overflow | underflow);
    end
  end
`else
  assign ctrl_rd = '0;
`endif
endmodule

// File: tb/tb_wishbone_nn_stream_if.sv
// tb/tb_wishbone_nn_stream_if.sv - randomized self-checking bench for wishbone_nn_stream_if
module tb_wishbone_nn_stream_if;
  localparam logic [31:0] A_DATA = 32'h30000000;
  localparam logic [31:0] A_STAT = 32'h30000004;
  localparam logic [31:0] A_CTRL = 32'h30000008;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wishbone_nn_stream_if_if bus();
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic [31:0] tx_data, rx_data;
`ifdef WB_NN_IRQ_EN
  logic irq;
`endif

  wishbone_nn_stream_if dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs       (bus),
    .tx_valid_o(tx_valid),
    .tx_data_o (tx_data),
    .tx_ready_i(tx_ready),
    .rx_valid_i(rx_valid),
    .rx_data_i (rx_data),
    .rx_ready_o(rx_ready)
`ifdef WB_NN_IRQ_EN
    ,
    .irq_o     (irq)
`endif
  );

  int tests_run = 0;
  int fails = 0;

  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  bit m_of, m_uf, m_irq_en;

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[7:0]  = 8'(tx_q.size());
    s[15:8] = 8'(rx_q.size());
    s[16]   = tx_q.size() == DEPTH;
    s[17]   = rx_q.size() == 0;
    s[18]   = m_of;
    s[19]   = m_uf;
    return s;
  endfunction

  // Bus cycle: starts and ends one time unit after a rising edge.
  task automatic bus_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic co_rx, input logic [31:0] co_data, output logic [31:0] rdata);
    bit got;
    int lat;
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = addr; bus.wbs_dat_i = wdata;
    if (co_rx) begin rx_valid = 1'b1; rx_data = co_data; end
    got = 0; lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b0;
      if (bus.wbs_ack_o === 1'b1) begin got = 1; lat = i; break; end
    end
    rdata = bus.wbs_dat_o;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    tests_run++;
    if (!got || lat != 0) begin
      fails++; $display("FAIL ack_latency addr=%h got_ack=%0d latency=%0d required ack at 0", addr, got, lat);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus.wbs_ack_o !== 1'b0) begin
      fails++; $display("FAIL ack_width addr=%h ack=%b required 0", addr, bus.wbs_ack_o);
    end
  endtask

  task automatic wb_write(input logic [31:0] addr, input logic [31:0] d);
    logic [31:0] r;
    if (addr == A_DATA) begin
      if (tx_q.size() < DEPTH) tx_q.push_back(d); else m_of = 1;
    end else if (addr == A_CTRL) begin
      if (d[0]) tx_q.delete();
      if (d[1]) rx_q.delete();
      if (d[2]) begin m_of = 0; m_uf = 0; end
`ifdef WB_NN_IRQ_EN
      m_irq_en = d[3];
`endif
    end
    bus_xfer(1'b1, addr, d, 1'b0, 32'd0, r);
    tests_run++;
    if (r !== 32'd0) begin fails++; $display("FAIL write_dat_o addr=%h got=%h required 0", addr, r); end
  endtask

  task automatic wb_read(input logic [31:0] addr, input logic co_rx, input logic [31:0] co_data,
                         output logic [31:0] got, output logic [31:0] exp);
    bit ready;
    exp = '0;
    if (addr == A_STAT) exp = exp_status();
    else if (addr == A_CTRL) exp = m_irq_en ? 32'h8 : 32'h0;
    else begin
      ready = rx_q.size() < DEPTH;
      if (rx_q.size() > 0) exp = rx_q.pop_front(); else m_uf = 1;
      if (co_rx && ready) rx_q.push_back(co_data);
    end
    bus_xfer(1'b0, addr, 32'd0, co_rx, co_data, got);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] g, e;
    wb_read(A_STAT, 1'b0, 32'd0, g, e);
    tests_run++;
    if (g !== e) begin fails++; $display("FAIL %s status got=%h required %h", tag, g, e); end
  endtask

  // One stream cycle: core-side ready/valid for a single edge.
  task automatic stream_step(input logic r, input logic v, input logic [31:0] d);
    tx_ready = r; rx_valid = v; rx_data = d;
    tests_run++;
    if (tx_valid !== (tx_q.size() > 0) || rx_ready !== (rx_q.size() < DEPTH)) begin
      fails++; $display("FAIL stream_flags tx_valid=%b rx_ready=%b required %b %b",
                        tx_valid, rx_ready, tx_q.size() > 0, rx_q.size() < DEPTH);
    end
    if (tx_q.size() > 0) begin
      tests_run++;
      if (tx_data !== tx_q[0]) begin fails++; $display("FAIL tx_head got=%h required %h", tx_data, tx_q[0]); end
    end
    @(posedge clk); #1;
    if (r && tx_q.size() > 0) void'(tx_q.pop_front());
    if (v && rx_q.size() < DEPTH) rx_q.push_back(d);
    tx_ready = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] g, e;
    bit seen;
    tests_run++;
    if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'd0) begin
      fails++; $display("FAIL reset_bus ack=%b dat=%h required 0 0", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    tests_run++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      fails++; $display("FAIL reset_stream tx_valid=%b rx_ready=%b required 0 1", tx_valid, rx_ready);
    end
    wb_read(A_STAT, 1'b0, 32'd0, g, e);
    tests_run++;
    if (g !== 32'h0002_0000) begin fails++; $display("FAIL reset_status got=%h required 00020000", g); end
    wb_read(A_CTRL, 1'b0, 32'd0, g, e);
    tests_run++;
    if (g !== 32'd0) begin fails++; $display("FAIL reset_ctrl got=%h required 0", g); end
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_adr_i = A_DATA + 32'd12; bus.wbs_we_i = 1'b1;
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (bus.wbs_ack_o !== 1'b0) seen = 1; end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    tests_run++;
    if (seen || tx_valid !== 1'b0) begin fails++; $display("FAIL miss_addr acked=%0d tx_valid=%b required 0 0", seen, tx_valid); end
  endtask

  task automatic test_tx_single();
    logic [31:0] g, e;
    tx_ready = 1'b0;
    wb_write(A_DATA, 32'hA5A5_0001);
    tests_run++;
    if (tx_valid !== 1'b1 || tx_data !== 32'hA5A5_0001) begin
      fails++; $display("FAIL tx_single valid=%b data=%h required 1 a5a50001", tx_valid, tx_data);
    end
    wb_read(A_STAT, 1'b0, 32'd0, g, e);
    tests_run++;
    if (g[7:0] !== 8'd1) begin fails++; $display("FAIL tx_single_count got=%0d required 1", g[7:0]); end
    stream_step(1'b1, 1'b0, 32'd0);
    tests_run++;
    if (tx_valid !== 1'b0) begin fails++; $display("FAIL tx_single_pop tx_valid=%b required 0", tx_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] g, e;
    for (int i = 0; i < 9; i++) wb_write(A_DATA, $urandom);
    wb_read(A_STAT, 1'b0, 32'd0, g, e);
    tests_run++;
    if (g[16] !== 1'b1 || g[18] !== 1'b1 || g !== e) begin
      fails++; $display("FAIL overflow_status got=%h required %h", g, e);
    end
    while (tx_q.size() > 0) stream_step(1'b1, 1'b0, 32'd0);
    tests_run++;
    if (tx_valid !== 1'b0) begin fails++; $display("FAIL overflow_drain tx_valid=%b required 0", tx_valid); end
    wb_write(A_CTRL, 32'h4);
    wb_read(A_STAT, 1'b0, 32'd0, g, e);
    tests_run++;
    if (g[18] !== 1'b0 || g !== e) begin fails++; $display("FAIL overflow_clear got=%h required %h", g, e); end
  endtask

  task automatic test_rx_underflow();
    logic [31:0] g, e;
    for (int i = 0; i < 3; i++) stream_step(1'b0, 1'b1, $urandom);
    for (int i = 0; i < 4; i++) begin
      wb_read(A_DATA, 1'b0, 32'd0, g, e);
      tests_run++;
      if (g !== e) begin fails++; $display("FAIL rx_read%0d got=%h required %h", i, g, e); end
    end
    wb_read(A_STAT, 1'b0, 32'd0, g, e);
    tests_run++;
    if (g[19] !== 1'b1 || g !== e) begin fails++; $display("FAIL underflow_status got=%h required %h", g, e); end
    stream_step(1'b0, 1'b1, $urandom);
    wb_read(A_DATA, 1'b1, $urandom, g, e);
    tests_run++;
    if (g !== e) begin fails++; $display("FAIL same_edge_data got=%h required %h", g, e); end
    wb_read(A_STAT, 1'b0, 32'd0, g, e);
    tests_run++;
    if (g[15:8] !== 8'd1 || g !== e) begin fails++; $display("FAIL same_edge_count got=%h required %h", g, e); end
    wb_write(A_CTRL, 32'h6);
  endtask

  task automatic test_flush();
    for (int i = 0; i < DEPTH + 1; i++) stream_step(1'b0, 1'b1, $urandom);
    tests_run++;
    if (rx_ready !== 1'b0) begin fails++; $display("FAIL rx_full_ready rx_ready=%b required 0", rx_ready); end
    check_status("rx_full");
    wb_write(A_CTRL, 32'h2);
    tests_run++;
    if (rx_ready !== 1'b1) begin fails++; $display("FAIL rx_flush_ready rx_ready=%b required 1", rx_ready); end
    check_status("rx_flush");
    for (int i = 0; i < 3; i++) wb_write(A_DATA, $urandom);
    wb_write(A_CTRL, 32'h1);
    tests_run++;
    if (tx_valid !== 1'b0) begin fails++; $display("FAIL tx_flush tx_valid=%b required 0", tx_valid); end
    check_status("tx_flush");
  endtask

  task automatic test_random();
    logic [31:0] g, e;
    int op;
    for (int n = 0; n < 120; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 2) wb_write(A_DATA, $urandom);
      else if (op <= 4) begin
        wb_read(A_DATA, 1'b0, 32'd0, g, e);
        tests_run++;
        if (g !== e) begin fails++; $display("FAIL rand_read n=%0d got=%h required %h", n, g, e); end
      end else if (op == 5) check_status("rand");
      else if (op <= 8) stream_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      else if ($urandom_range(0, 3) == 0) wb_write(A_CTRL, 32'($urandom_range(0, 15)));
      else begin
        wb_read(A_CTRL, 1'b0, 32'd0, g, e);
        tests_run++;
        if (g !== e) begin fails++; $display("FAIL rand_ctrl got=%h required %h", g, e); end
      end
    end
    check_status("rand_end");
  endtask

  task automatic test_reset_mid_ack();
    wb_write(A_DATA, $urandom);
    stream_step(1'b0, 1'b1, $urandom);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = A_DATA; bus.wbs_dat_i = $urandom;
    @(posedge clk); #1;
    tests_run++;
    if (bus.wbs_ack_o !== 1'b1) begin fails++; $display("FAIL mid_ack_pre ack=%b required 1", bus.wbs_ack_o); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.wbs_ack_o !== 1'b0 || tx_valid !== 1'b0 || rx_ready !== 1'b0) begin
      fails++; $display("FAIL mid_ack_reset ack=%b tx_valid=%b rx_ready=%b required 0 0 0",
                        bus.wbs_ack_o, tx_valid, rx_ready);
    end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tx_q.delete(); rx_q.delete(); m_of = 0; m_uf = 0; m_irq_en = 0;
    check_status("post_reset");
  endtask

`ifdef WB_NN_IRQ_EN
  task automatic test_irq();
    logic [31:0] g, e;
    wb_write(A_CTRL, 32'hE);
    tests_run++;
    if (irq !== 1'b0) begin fails++; $display("FAIL irq_idle irq=%b required 0", irq); end
    stream_step(1'b0, 1'b1, $urandom);
    @(posedge clk); #1;
    tests_run++;
    if (irq !== 1'b1) begin fails++; $display("FAIL irq_set irq=%b required 1", irq); end
    wb_read(A_DATA, 1'b0, 32'd0, g, e);
    tests_run++;
    if (irq !== 1'b0 || g !== e) begin fails++; $display("FAIL irq_clear irq=%b data=%h required 0 %h", irq, g, e); end
    wb_read(A_CTRL, 1'b0, 32'd0, g, e);
    tests_run++;
    if (g !== 32'h8) begin fails++; $display("FAIL irq_ctrl_read got=%h required 8", g); end
  endtask
`endif

  initial begin
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    m_of = 0; m_uf = 0; m_irq_en = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_tx_single();
    test_overflow();
    test_rx_underflow();
    test_flush();
    test_random();
    test_reset_mid_ack();
`ifdef WB_NN_IRQ_EN
    test_irq();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
